// File: rtl/processing_unit_multi_context.sv
// Union-find decoding PE with an on-chip store of NUM_CONTEXTS lattice-layer contexts.
// Optional macro PE_CTX_PARITY_EN adds a per-slot even-parity bit and a sticky ctx_parity_error output.
module processing_unit_multi_context #(
    parameter int ADDRESS_WIDTH  = 6,
    parameter int NEIGHBOR_COUNT = 6,
    parameter int NUM_CONTEXTS   = 4,
    parameter int STAGE_WIDTH    = 3,
    localparam int CW = $clog2((NUM_CONTEXTS > 1) ? NUM_CONTEXTS : 2),
    localparam int FW = ADDRESS_WIDTH + 3
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           measurement,
    output logic                           measurement_out,
    input  logic [STAGE_WIDTH-1:0]         global_stage,
    input  logic [NEIGHBOR_COUNT-1:0]      neighbor_fully_grown,
    input  logic [NEIGHBOR_COUNT-1:0]      neighbor_is_boundary,
    output logic                           neighbor_increase,
    output logic [NEIGHBOR_COUNT-1:0]      neighbor_is_error,
    input  logic [ADDRESS_WIDTH-1:0]       input_address,
    input  logic [NEIGHBOR_COUNT*FW-1:0]   input_data,
    output logic [NEIGHBOR_COUNT*FW-1:0]   output_data,
    output logic [ADDRESS_WIDTH-1:0]       root,
    output logic                           odd,
    output logic                           busy,
`ifdef PE_CTX_PARITY_EN
    output logic                           ctx_parity_error,
`endif
    output logic [CW-1:0]                  context_id
);
    localparam logic [STAGE_WIDTH-1:0] STAGE_IDLE         = STAGE_WIDTH'(0);
    localparam logic [STAGE_WIDTH-1:0] STAGE_MEAS_LOADING = STAGE_WIDTH'(1);
    localparam logic [STAGE_WIDTH-1:0] STAGE_GROW         = STAGE_WIDTH'(2);
    localparam logic [STAGE_WIDTH-1:0] STAGE_MERGE        = STAGE_WIDTH'(3);
    localparam logic [STAGE_WIDTH-1:0] STAGE_PEELING      = STAGE_WIDTH'(4);
    localparam logic [STAGE_WIDTH-1:0] STAGE_RESET_ROOTS  = STAGE_WIDTH'(5);
    localparam logic [STAGE_WIDTH-1:0] STAGE_WRITE_TO_MEM = STAGE_WIDTH'(6);

    localparam int LW = ADDRESS_WIDTH + NEIGHBOR_COUNT + 3;
`ifdef PE_CTX_PARITY_EN
    localparam int SW = LW + 1;
`else
    localparam int SW = LW;
`endif

    logic [STAGE_WIDTH-1:0]    stage_p0, last_stage_p1;
    logic                      m, cluster_parity;
    logic [NEIGHBOR_COUNT-1:0] parent_vector;
    logic [NUM_CONTEXTS-1:0]   slot_valid;
    logic [SW-1:0]             slot_mem [NUM_CONTEXTS];

    logic [ADDRESS_WIDTH-1:0]  nb_root [NEIGHBOR_COUNT];
    logic [NEIGHBOR_COUNT-1:0] nb_parent, nb_odd, nb_par;
    logic [ADDRESS_WIDTH-1:0]  root_mod, cand, merge_root;
    logic [NEIGHBOR_COUNT-1:0] candvec, merge_pv, border;
    logic                      cand_found, next_par, merge_odd, merge_busy, any_boundary;
    logic [CW-1:0]             nxt;
    logic [LW-1:0]             live_word, rd_live;
    logic [SW-1:0]             save_word, rd_word;

    always_comb begin
        for (int i = 0; i < NEIGHBOR_COUNT; i++) begin
            nb_root[i]   = input_data[i*FW +: ADDRESS_WIDTH];
            nb_parent[i] = input_data[i*FW + ADDRESS_WIDTH];
            nb_odd[i]    = input_data[i*FW + ADDRESS_WIDTH + 1];
            nb_par[i]    = input_data[i*FW + ADDRESS_WIDTH + 2];
            output_data[i*FW +: FW] = {cluster_parity, odd, parent_vector[i], root};
        end
    end

    // Merge decision: smallest grown non-boundary neighbour root wins, ties to lowest link
    always_comb begin
        any_boundary = |neighbor_is_boundary;
        root_mod     = any_boundary ? {1'b0, input_address[ADDRESS_WIDTH-2:0]} : root;
        cand_found   = 1'b0;
        cand         = '1;
        candvec      = '0;
        for (int i = 0; i < NEIGHBOR_COUNT; i++) begin
            if (neighbor_fully_grown[i] && !neighbor_is_boundary[i] && (!cand_found || nb_root[i] < cand)) begin
                cand       = nb_root[i];
                candvec    = '0;
                candvec[i] = 1'b1;
                cand_found = 1'b1;
            end
        end
        next_par = (^(nb_parent & nb_par)) ^ m;
        if (cand_found && cand < root && cand < root_mod) begin
            merge_root = cand;
            merge_pv   = candvec;
        end else if (root_mod < root) begin
            merge_root = root_mod;
            merge_pv   = '0;
        end else begin
            merge_root = root;
            merge_pv   = parent_vector;
        end
        merge_odd  = (|merge_pv) ? |(merge_pv & nb_odd) : (next_par & ~any_boundary);
        merge_busy = (merge_root != root) || (merge_pv != parent_vector) ||
                     (next_par != cluster_parity) || (merge_odd != odd);
    end

    always_comb begin
        border = '0;
        for (int i = 0; i < NEIGHBOR_COUNT; i++) begin
            if (neighbor_is_boundary[i]) begin
                border    = '0;
                border[i] = 1'b1;
            end
        end
        if (parent_vector != '0 || !next_par) border = '0;
        neighbor_is_error = '0;
        if (stage_p0 == STAGE_PEELING)
            neighbor_is_error = (cluster_parity ? parent_vector : '0) | border;
        neighbor_increase = (stage_p0 == STAGE_GROW && last_stage_p1 != STAGE_GROW) ? odd : 1'b0;
        measurement_out   = m;
    end

    always_comb begin
        nxt       = (context_id == CW'(NUM_CONTEXTS - 1)) ? '0 : context_id + CW'(1);
        live_word = {cluster_parity, parent_vector, root, odd, m};
`ifdef PE_CTX_PARITY_EN
        save_word = {^live_word, live_word};
`else
        save_word = live_word;
`endif
        rd_word   = slot_mem[nxt];
        rd_live   = rd_word[LW-1:0];
    end

    // Context store: data array carries no reset, only the valid bits do
    always_ff @(posedge clk) begin
        if (!reset && stage_p0 == STAGE_WRITE_TO_MEM)
            slot_mem[context_id] <= save_word;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stage_p0       <= STAGE_IDLE;
            last_stage_p1  <= STAGE_IDLE;
            m              <= 1'b0;
            odd            <= 1'b0;
            cluster_parity <= 1'b0;
            busy           <= 1'b0;
            parent_vector  <= '0;
            root           <= input_address;
            context_id     <= '0;
            slot_valid     <= '0;
`ifdef PE_CTX_PARITY_EN
            ctx_parity_error <= 1'b0;
`endif
        end else begin
            stage_p0      <= global_stage;
            last_stage_p1 <= stage_p0;
            case (stage_p0)
                STAGE_MEAS_LOADING: begin
                    m              <= measurement;
                    odd            <= measurement;
                    cluster_parity <= measurement;
                    root           <= input_address;
                    parent_vector  <= '0;
                end
                STAGE_MERGE: begin
                    root           <= merge_root;
                    parent_vector  <= merge_pv;
                    cluster_parity <= next_par;
                    odd            <= merge_odd;
                    busy           <= merge_busy;
                end
                STAGE_RESET_ROOTS: begin
                    root          <= input_address;
                    parent_vector <= '0;
                end
                STAGE_WRITE_TO_MEM: begin
                    slot_valid[context_id] <= 1'b1;
                    if (NUM_CONTEXTS > 1) begin
                        context_id <= nxt;
                        if (slot_valid[nxt]) begin
                            {cluster_parity, parent_vector, root, odd, m} <= rd_live;
`ifdef PE_CTX_PARITY_EN
                            if (^rd_word) ctx_parity_error <= 1'b1;
`endif
                        end else begin
                            cluster_parity <= 1'b0;
                            parent_vector  <= '0;
                            root           <= input_address;
                            odd            <= 1'b0;
                            m              <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
